// File: rtl/fb_rect_fill.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : fb_rect_fill                                                  |
// | Description : Fills a clipped rectangle of the RGB444 frame buffer with one |
// |               colour, emitting the rate-limited WR/WADDR/DIN nibble stream. |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module fb_rect_fill #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 240,
    parameter int WR_GAP = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [7:0]  CMD_X0,
    input  logic [7:0]  CMD_Y0,
    input  logic [8:0]  CMD_W,
    input  logic [8:0]  CMD_H,
    input  logic [11:0] CMD_COLOR,
    output logic        BUSY,
    output logic        DONE,
    output logic        WR,
    output logic [19:0] WADDR,
    output logic [7:0]  DIN
);

    localparam logic [2:0]  c_st_idle  = 3'd0;
    localparam logic [2:0]  c_st_setup = 3'd1;
    localparam logic [2:0]  c_st_write = 3'd2;
    localparam logic [2:0]  c_st_gap   = 3'd3;
    localparam logic [2:0]  c_st_fin   = 3'd4;

    localparam logic [9:0]  c_width10  = 10'(WIDTH);
    localparam logic [9:0]  c_height10 = 10'(HEIGHT);
    localparam logic [19:0] c_width20  = 20'(WIDTH);
    localparam logic [19:0] c_row_step = 20'(3 * WIDTH);
    localparam logic [15:0] c_gap_init = 16'(WR_GAP - 1);

    logic [2:0]  r_state;
    logic [7:0]  r_x0;
    logic [7:0]  r_y0;
    logic [8:0]  r_w;
    logic [8:0]  r_h;
    logic [11:0] r_color;
    logic [9:0]  r_cw;
    logic [9:0]  r_ch;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [1:0]  r_k;
    logic [19:0] r_row_base;
    logic [19:0] r_addr;
    logic [15:0] r_gap;
    logic        r_last;
    logic        r_wr;
    logic        r_done;
    logic [19:0] r_waddr;
    logic [7:0]  r_din;

    logic [9:0]  w_room_x;
    logic [9:0]  w_room_y;
    logic [9:0]  w_cw;
    logic [9:0]  w_ch;
    logic        w_empty;
    logic [19:0] w_base;
    logic [3:0]  w_nib;
    logic        w_last_k;
    logic        w_last_x;
    logic        w_last_y;

    // Room left to the frame edge; only meaningful when the origin is on-frame.
    assign w_room_x = c_width10 - {2'b00, r_x0};
    assign w_room_y = c_height10 - {2'b00, r_y0};
    assign w_cw     = ({1'b0, r_w} < w_room_x) ? {1'b0, r_w} : w_room_x;
    assign w_ch     = ({1'b0, r_h} < w_room_y) ? {1'b0, r_h} : w_room_y;
    assign w_empty  = ({2'b00, r_x0} >= c_width10) || ({2'b00, r_y0} >= c_height10) ||
                      (r_w == 9'd0) || (r_h == 9'd0);
    assign w_base   = (({12'b0, r_y0} * c_width20) + {12'b0, r_x0}) * 20'd3;

    always_comb begin
        w_nib = r_color[11:8];
        case (r_k)
            2'd1:    w_nib = r_color[7:4];
            2'd2:    w_nib = r_color[3:0];
            default: w_nib = r_color[11:8];
        endcase
    end

    assign w_last_k = (r_k == 2'd2);
    assign w_last_x = (r_x == (r_cw - 10'd1));
    assign w_last_y = (r_y == (r_ch - 10'd1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= c_st_idle;
            r_x0       <= 8'd0;
            r_y0       <= 8'd0;
            r_w        <= 9'd0;
            r_h        <= 9'd0;
            r_color    <= 12'd0;
            r_cw       <= 10'd0;
            r_ch       <= 10'd0;
            r_x        <= 10'd0;
            r_y        <= 10'd0;
            r_k        <= 2'd0;
            r_row_base <= 20'd0;
            r_addr     <= 20'd0;
            r_gap      <= 16'd0;
            r_last     <= 1'b0;
            r_wr       <= 1'b0;
            r_done     <= 1'b0;
            r_waddr    <= 20'd0;
            r_din      <= 8'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_done <= 1'b0;
                    if (CMD_VALID) begin
                        r_x0    <= CMD_X0;
                        r_y0    <= CMD_Y0;
                        r_w     <= CMD_W;
                        r_h     <= CMD_H;
                        r_color <= CMD_COLOR;
                        r_k     <= 2'd0;
                        r_state <= c_st_setup;
                    end
                end
                c_st_setup: begin
                    r_cw <= w_cw;
                    r_ch <= w_ch;
                    r_x  <= 10'd0;
                    r_y  <= 10'd0;
                    if (w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= c_st_fin;
                    end else begin
                        r_wr       <= 1'b1;
                        r_waddr    <= w_base;
                        r_din      <= {w_nib, 4'h0};
                        r_addr     <= w_base;
                        r_row_base <= w_base;
                        r_state    <= c_st_write;
                    end
                end
                c_st_write: begin
                    r_wr    <= 1'b0;
                    r_gap   <= c_gap_init;
                    r_last  <= w_last_k && w_last_x && w_last_y;
                    r_state <= c_st_gap;
                    // Counters stop on the final nibble so r_addr stays in-frame.
                    if (!(w_last_k && w_last_x && w_last_y)) begin
                        if (!w_last_k) begin
                            r_k    <= r_k + 2'd1;
                            r_addr <= r_addr + 20'd1;
                        end else if (!w_last_x) begin
                            r_k    <= 2'd0;
                            r_x    <= r_x + 10'd1;
                            r_addr <= r_addr + 20'd1;
                        end else begin
                            r_k        <= 2'd0;
                            r_x        <= 10'd0;
                            r_y        <= r_y + 10'd1;
                            r_row_base <= r_row_base + c_row_step;
                            r_addr     <= r_row_base + c_row_step;
                        end
                    end
                end
                c_st_gap: begin
                    if (r_gap == 16'd0) begin
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= c_st_fin;
                        end else begin
                            r_wr    <= 1'b1;
                            r_waddr <= r_addr;
                            r_din   <= {w_nib, 4'h0};
                            r_state <= c_st_write;
                        end
                    end else begin
                        r_gap <= r_gap - 16'd1;
                    end
                end
                c_st_fin: begin
                    r_done  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_wr    <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign CMD_READY = (r_state == c_st_idle);
    assign BUSY      = (r_state != c_st_idle);
    assign DONE      = r_done;
    assign WR        = r_wr;
    assign WADDR     = r_waddr;
    assign DIN       = r_din;

endmodule
`default_nettype wire

// File: tb/tb_fb_rect_fill.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_fb_rect_fill                                               |
// | Description : Directed self-checking bench for fb_rect_fill (240x240 gap 1  |
// |               instance plus a 20x12 gap 3 instance for full-frame fills).   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_fb_rect_fill;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic        r_vld_m;
    logic        r_vld_s;
    logic        r_sel;
    logic [7:0]  r_x0;
    logic [7:0]  r_y0;
    logic [8:0]  r_w;
    logic [8:0]  r_h;
    logic [11:0] r_col;

    logic        w_ready_m, w_busy_m, w_done_m, w_wr_m;
    logic [19:0] w_waddr_m;
    logic [7:0]  w_din_m;
    logic        w_ready_s, w_busy_s, w_done_s, w_wr_s;
    logic [19:0] w_waddr_s;
    logic [7:0]  w_din_s;

    logic        w_ready, w_busy, w_done, w_wr;
    logic [19:0] w_waddr;
    logic [7:0]  w_din;

    int n_checks = 0;
    int n_errors = 0;

    always #5 r_clk = ~r_clk;

    fb_rect_fill #(.WIDTH(240), .HEIGHT(240), .WR_GAP(1)) dut (
        .CLK(r_clk), .RST(r_rst), .CMD_VALID(r_vld_m), .CMD_READY(w_ready_m),
        .CMD_X0(r_x0), .CMD_Y0(r_y0), .CMD_W(r_w), .CMD_H(r_h), .CMD_COLOR(r_col),
        .BUSY(w_busy_m), .DONE(w_done_m), .WR(w_wr_m), .WADDR(w_waddr_m), .DIN(w_din_m)
    );

    fb_rect_fill #(.WIDTH(20), .HEIGHT(12), .WR_GAP(3)) dut_s (
        .CLK(r_clk), .RST(r_rst), .CMD_VALID(r_vld_s), .CMD_READY(w_ready_s),
        .CMD_X0(r_x0), .CMD_Y0(r_y0), .CMD_W(r_w), .CMD_H(r_h), .CMD_COLOR(r_col),
        .BUSY(w_busy_s), .DONE(w_done_s), .WR(w_wr_s), .WADDR(w_waddr_s), .DIN(w_din_s)
    );

    assign w_ready = r_sel ? w_ready_s : w_ready_m;
    assign w_busy  = r_sel ? w_busy_s  : w_busy_m;
    assign w_done  = r_sel ? w_done_s  : w_done_m;
    assign w_wr    = r_sel ? w_wr_s    : w_wr_m;
    assign w_waddr = r_sel ? w_waddr_s : w_waddr_m;
    assign w_din   = r_sel ? w_din_s   : w_din_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Issues one command and checks the whole nibble stream against a walk of the rectangle.
    task automatic run_cmd(input bit sel, input int cx0, input int cy0, input int cw_in,
                           input int ch_in, input int color, input int exp_n,
                           input int exp_done, input int exp_first, input int exp_last,
                           input bit poke, input string tag);
        int fw, fh, gap, mcw, mch, ex, ey, ek, n, last_c, done_c, overlap, busy_bad;
        int first_a, last_a, exp_a, exp_d;
        fw = sel ? 20 : 240;
        fh = sel ? 12 : 240;
        gap = sel ? 3 : 1;
        mcw = (cx0 >= fw) ? 0 : ((cw_in < fw - cx0) ? cw_in : fw - cx0);
        mch = (cy0 >= fh) ? 0 : ((ch_in < fh - cy0) ? ch_in : fh - cy0);
        ex = 0; ey = 0; ek = 0; n = 0; last_c = 0; done_c = 0; overlap = 0; busy_bad = 0;
        first_a = -1; last_a = -1;
        r_sel = sel;
        r_x0 = 8'(cx0); r_y0 = 8'(cy0); r_w = 9'(cw_in); r_h = 9'(ch_in); r_col = 12'(color);
        if (sel) r_vld_s = 1'b1; else r_vld_m = 1'b1;
        @(negedge r_clk);
        r_vld_s = 1'b0; r_vld_m = 1'b0;
        for (int c = 1; c <= exp_done + 20; c++) begin
            if (poke && c == 3) begin
                r_x0 = 8'd1; r_y0 = 8'd1; r_w = 9'd50; r_h = 9'd50; r_col = 12'hFFF;
                if (sel) r_vld_s = 1'b1; else r_vld_m = 1'b1;
            end
            if (poke && c == 4) begin
                r_vld_s = 1'b0; r_vld_m = 1'b0;
            end
            if (w_wr === 1'b1) begin
                n++;
                if (n == 1) begin
                    check({tag, "_first_wr_cycle"}, 32'(c), 32'd2);
                    first_a = int'(w_waddr);
                end else begin
                    check({tag, "_wr_spacing"}, 32'(c - last_c), 32'(gap + 1));
                end
                last_c = c;
                exp_a = ((cy0 + ey) * fw + cx0 + ex) * 3 + ek;
                exp_d = ((color >> (8 - 4 * ek)) & 15) << 4;
                check({tag, "_waddr"}, 32'(w_waddr), 32'(exp_a));
                check({tag, "_din"}, 32'(w_din), 32'(exp_d));
                last_a = int'(w_waddr);
                ek++;
                if (ek == 3) begin ek = 0; ex++; end
                if (ex == mcw) begin ex = 0; ey++; end
                if (w_done === 1'b1) overlap++;
            end
            if (w_busy !== 1'b1) busy_bad++;
            if (w_done === 1'b1) begin
                done_c = c;
                break;
            end
            @(negedge r_clk);
        end
        check({tag, "_wr_count"}, 32'(n), 32'(exp_n));
        check({tag, "_model_count"}, 32'(n), 32'(3 * mcw * mch));
        check({tag, "_done_cycle"}, 32'(done_c), 32'(exp_done));
        check({tag, "_done_wr_overlap"}, 32'(overlap), 32'd0);
        check({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
        if (exp_n > 0) begin
            check({tag, "_first_addr"}, 32'(first_a), 32'(exp_first));
            check({tag, "_last_addr"}, 32'(last_a), 32'(exp_last));
        end
        @(negedge r_clk);
        check({tag, "_ready_after"}, 32'(w_ready), 32'd1);
        check({tag, "_busy_after"}, 32'(w_busy), 32'd0);
        check({tag, "_done_after"}, 32'(w_done), 32'd0);
        @(negedge r_clk);
        check({tag, "_not_queued"}, 32'(w_busy), 32'd0);
    endtask

    initial begin
        int cnt, extra_wr, extra_done, extra_busy;
        r_rst = 1'b1; r_vld_m = 1'b0; r_vld_s = 1'b0; r_sel = 1'b0;
        r_x0 = 8'd0; r_y0 = 8'd0; r_w = 9'd0; r_h = 9'd0; r_col = 12'd0;
        repeat (3) @(negedge r_clk);
        check("rst_wr", 32'(w_wr_m), 32'd0);
        check("rst_waddr", 32'(w_waddr_m), 32'd0);
        check("rst_din", 32'(w_din_m), 32'd0);
        check("rst_done", 32'(w_done_m), 32'd0);
        check("rst_busy", 32'(w_busy_m), 32'd0);
        check("rst_ready", 32'(w_ready_m), 32'd1);
        check("rst_ready_s", 32'(w_ready_s), 32'd1);
        r_rst = 1'b0;
        @(negedge r_clk);

        run_cmd(0, 0, 0, 1, 1, 12'hABC, 3, 8, 0, 2, 0, "t1");
        run_cmd(0, 239, 239, 1, 1, 12'hF0F, 3, 8, 172797, 172799, 0, "t2");
        run_cmd(0, 230, 0, 20, 2, 12'h123, 60, 122, 690, 1439, 0, "t3");
        run_cmd(0, 0, 235, 1, 10, 12'h4D2, 15, 32, 169200, 172082, 0, "clip_y");
        run_cmd(0, 240, 5, 4, 4, 12'h111, 0, 2, 0, 0, 0, "t4_x_off");
        run_cmd(0, 0, 0, 0, 7, 12'h222, 0, 2, 0, 0, 0, "t4_w0");
        run_cmd(0, 5, 5, 2, 2, 12'h9C6, 12, 26, 3615, 4340, 1, "poke");
        run_cmd(0, 0, 0, 240, 10, 12'h000, 7200, 14402, 0, 7199, 0, "t5_band");
        run_cmd(1, 0, 0, 20, 12, 12'h5A3, 720, 2882, 0, 719, 0, "t5_full_g3");
        run_cmd(1, 0, 0, 300, 300, 12'h3C9, 720, 2882, 0, 719, 0, "t5_clip_g3");

        // Abort mid-fill with reset after the fifth nibble.
        r_sel = 1'b0;
        r_x0 = 8'd10; r_y0 = 8'd10; r_w = 9'd4; r_h = 9'd4; r_col = 12'h777;
        r_vld_m = 1'b1;
        @(negedge r_clk);
        r_vld_m = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (w_wr_m === 1'b1) cnt++;
            if (cnt == 5) break;
            @(negedge r_clk);
        end
        check("t6_wr_before_rst", 32'(cnt), 32'd5);
        check("t6_fifth_addr", 32'(w_waddr_m), 32'd7234);
        r_rst = 1'b1;
        @(negedge r_clk);
        check("t6_rst_wr", 32'(w_wr_m), 32'd0);
        check("t6_rst_done", 32'(w_done_m), 32'd0);
        check("t6_rst_busy", 32'(w_busy_m), 32'd0);
        check("t6_rst_ready", 32'(w_ready_m), 32'd1);
        check("t6_rst_waddr", 32'(w_waddr_m), 32'd0);
        r_rst = 1'b0;
        extra_wr = 0; extra_done = 0; extra_busy = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge r_clk);
            if (w_wr_m === 1'b1) extra_wr++;
            if (w_done_m === 1'b1) extra_done++;
            if (w_busy_m === 1'b1) extra_busy++;
        end
        check("t6_no_wr_after", 32'(extra_wr), 32'd0);
        check("t6_no_done_after", 32'(extra_done), 32'd0);
        check("t6_idle_after", 32'(extra_busy), 32'd0);
        run_cmd(0, 0, 0, 1, 1, 12'hABC, 3, 8, 0, 2, 0, "t6_rerun");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
